vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing generator: divides the system clock down to the pixel rate and produces registered hsync, vsync, visible, col and row. Adds line_start/frame_start strobes, a run enable and optional frame counting. It sits between the system clock domain and the pixel pipeline (framebuffer reader, pattern generators, RGB output stage), all of which run on the same clock and qualify on new_pxl.

## Interface
- C_CLK_DIV, 4: system clocks per pixel (≥1; 4 gives 25 MHz from 100 MHz)
- C_H_VISIBLE / C_H_FPORCH / C_H_SYNC / C_H_BPORCH, 640/16/96/48: horizontal phases in pixels
- C_V_VISIBLE / C_V_FPORCH / C_V_SYNC / C_V_BPORCH, 480/10/2/33: vertical phases in lines
- C_HSYNC_ACT, 0: active level of hsync
- C_VSYNC_ACT, 0: active level of vsync
- C_NB_PXLS, 10 and C_NB_LINES, 10: col/row widths; H total and V total must each be ≤ 2^width
- C_NB_FRAME, 8: frame_cnt width
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low holds the generator in its reset state (synchronous)
- new_pxl  out  1  one-clk strobe on the first clk of each new pixel
- line_start  out  1  new_pxl && col==0
- frame_start  out  1  new_pxl && col==0 && row==0
- visible  out  1  col < C_H_VISIBLE && row < C_V_VISIBLE
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- col  out  C_NB_PXLS  current pixel column
- row  out  C_NB_LINES  current line
- frame_cnt  out  C_NB_FRAME  frame counter (see Configuration)

## Operation
- H_TOTAL = sum of the H phases (800). V_TOTAL = sum of the V phases (525).
- Clock divider cnt_clk counts 0..C_CLK_DIV-1. The internal tick fires when cnt_clk==C_CLK_DIV-1. C_CLK_DIV=1 ticks every clk.
- On each tick, col increments. At H_TOTAL-1 col wraps to 0 and row increments. At V_TOTAL-1 row wraps to 0.
- Horizontal phases: visible [0, C_H_VISIBLE); front porch next; hsync = C_HSYNC_ACT only during the sync phase; back porch last. Vertical phases follow the same pattern with vsync and C_VSYNC_ACT.
- All outputs are registered, and decode is computed from the next counter values. visible, hsync and vsync therefore always match the col/row presented in the same cycle, with no combinational skew.
- Reset values: cnt_clk=0, col=H_TOTAL-1, row=V_TOTAL-1, visible=0, hsync=!C_HSYNC_ACT, vsync=!C_VSYNC_ACT, new_pxl=0, line_start=0, frame_start=0, frame_cnt=0. This is the last back-porch pixel, so the first tick produces (0,0) together with frame_start.
- en=0 at a clk edge loads the reset values. The rise of en starts a fresh frame exactly as after reset. Asserting rst_n low mid-frame clears everything immediately (asynchronous).

## Timing
- After rst_n deasserts with en=1, the first new_pxl occurs at clk edge C_CLK_DIV, presenting col=0, row=0, visible=1, frame_start=1 and line_start=1.
- new_pxl, line_start and frame_start are each high for exactly one clk. The exception is C_CLK_DIV=1, where new_pxl stays high continuously.
- col/row/visible/sync values are stable for C_CLK_DIV clks, from the new_pxl cycle to the clk before the next new_pxl.
- line_start period = H_TOTAL·C_CLK_DIV clks. frame_start period = H_TOTAL·V_TOTAL·C_CLK_DIV clks.
- The row change and col wrap occur on the same edge. vsync transitions only together with a line_start.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt increments on the edge that asserts frame_start, starting at 1 for the first frame and wrapping from 2^C_NB_FRAME-1 to 0. It is cleared by rst_n and by en=0.
- VGA_TIMING_FRAME_CNT_EN undefined: frame_cnt is tied to 0 and no counter logic is generated. All other behaviour is identical.

## Structure
- The shared package vga_timing_pkg holds:
  - 640x480@60 phase constants
  - H_TOTAL/V_TOTAL derivation
  - the phase enumeration (VISIBLE, FPORCH, SYNC, BPORCH)
- One sub-module, vga_axis_cnt, is instantiated twice (horizontal and vertical). It is a wrap counter with step enable, end flag and phase decode, parametrised by the four phase lengths and width.

## Test plan
- Reset, then en=1 with defaults: first new_pxl at edge 4 with col=0, row=0, visible=1, frame_start=1; next new_pxl 4 clks later with col=1.
- Horizontal sweep: hsync low exactly for col 656..751 (96 pixels, 384 clks); visible low from col 640; line_start every 3200 clks.
- Vertical sweep: vsync low exactly for rows 490..491; frame_start every 1,680,000 clks; row wraps 524→0 on the same edge col wraps 799→0.
- C_CLK_DIV=1, C_HSYNC_ACT=1, C_VSYNC_ACT=1: new_pxl constantly high after edge 1; hsync/vsync active-high over the same ranges.
- en dropped at col=300, row=200 for 10 clks, then raised: outputs return to reset values on the next edge; frame_start occurs 4 clks after en rises.
- With VGA_TIMING_FRAME_CNT_EN and C_NB_FRAME=2: frame_cnt reads 1,2,3,0 over four frames; rst_n asserted mid-frame → all outputs at reset values immediately.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared definitions for the VGA timing generator.
//   - 640x480@60 phase constants (pixels / lines)
//   - H/V total derivation
//   - phase enumeration and a position -> phase helper
package vga_timing_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FPORCH  = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BPORCH  = 48;

  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FPORCH  = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BPORCH  = 33;

  localparam int unsigned VGA_H_TOTAL =
    VGA_H_VISIBLE + VGA_H_FPORCH + VGA_H_SYNC + VGA_H_BPORCH;
  localparam int unsigned VGA_V_TOTAL =
    VGA_V_VISIBLE + VGA_V_FPORCH + VGA_V_SYNC + VGA_V_BPORCH;

  // Phases of one axis, in the order they occur along the line/frame.
  typedef enum logic [1:0] {
    VISIBLE = 2'd0,
    FPORCH  = 2'd1,
    SYNC    = 2'd2,
    BPORCH  = 2'd3
  } phase_e;

  function automatic int unsigned axis_total(input int unsigned vis,
                                             input int unsigned fp,
                                             input int unsigned sy,
                                             input int unsigned bp);
    return vis + fp + sy + bp;
  endfunction

  // Phase containing position pos; anything past the sync phase is back porch.
  function automatic phase_e phase_of(input int unsigned pos,
                                      input int unsigned vis,
                                      input int unsigned fp,
                                      input int unsigned sy);
    if (pos < vis)                return VISIBLE;
    else if (pos < vis + fp)      return FPORCH;
    else if (pos < vis + fp + sy) return SYNC;
    else                          return BPORCH;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: wrap counter for one VGA axis (columns or lines).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous load of the reset position (last back-porch slot)
//   step        advance by one position, wrapping TOTAL-1 -> 0
//   cnt         current position (registered)
//   cnt_end     cnt == TOTAL-1
//   phase_nxt   phase of the position cnt will hold after this edge, so the
//               parent can register decode aligned with the counter
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned C_VISIBLE = 640,
  parameter int unsigned C_FPORCH  = 16,
  parameter int unsigned C_SYNC    = 96,
  parameter int unsigned C_BPORCH  = 48,
  parameter int unsigned C_NB      = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            step,
  output logic [C_NB-1:0] cnt,
  output logic            cnt_end,
  output logic [1:0]      phase_nxt
);

  localparam int unsigned TOTAL = axis_total(C_VISIBLE, C_FPORCH, C_SYNC, C_BPORCH);
  localparam logic [C_NB-1:0] LAST = C_NB'(TOTAL - 1);

  logic [C_NB-1:0] cnt_nxt;

  assign cnt_end = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (clr)       cnt_nxt = LAST;
    else if (step) cnt_nxt = cnt_end ? '0 : cnt + 1'b1;
  end

  always_comb begin
    phase_nxt = phase_of(32'(cnt_nxt), C_VISIBLE, C_FPORCH, C_SYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= LAST;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator.
// Divides clk by C_CLK_DIV to the pixel rate and produces registered col/row,
// visible, hsync/vsync and the new_pxl / line_start / frame_start strobes.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   en           run enable; low holds everything at the reset state
//   new_pxl      one-clk strobe on the first clk of each pixel
//   line_start   new_pxl at col 0;  frame_start  new_pxl at col 0, row 0
//   visible      inside the active area
//   hsync/vsync  sync outputs, active level C_HSYNC_ACT / C_VSYNC_ACT
//   col, row     current pixel position
//   frame_cnt    frame counter; only counts when VGA_TIMING_FRAME_CNT_EN is
//                defined, otherwise tied to zero
// Valid/ready: there is no handshake; consumers qualify on new_pxl, and all
// position/decode outputs hold for C_CLK_DIV clks from that strobe.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned C_CLK_DIV   = 4,
  parameter int unsigned C_H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned C_H_FPORCH  = VGA_H_FPORCH,
  parameter int unsigned C_H_SYNC    = VGA_H_SYNC,
  parameter int unsigned C_H_BPORCH  = VGA_H_BPORCH,
  parameter int unsigned C_V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned C_V_FPORCH  = VGA_V_FPORCH,
  parameter int unsigned C_V_SYNC    = VGA_V_SYNC,
  parameter int unsigned C_V_BPORCH  = VGA_V_BPORCH,
  parameter logic        C_HSYNC_ACT = 1'b0,
  parameter logic        C_VSYNC_ACT = 1'b0,
  parameter int unsigned C_NB_PXLS   = 10,
  parameter int unsigned C_NB_LINES  = 10,
  parameter int unsigned C_NB_FRAME  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  new_pxl,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  visible,
  output logic                  hsync,
  output logic                  vsync,
  output logic [C_NB_PXLS-1:0]  col,
  output logic [C_NB_LINES-1:0] row,
  output logic [C_NB_FRAME-1:0] frame_cnt
);

  localparam int unsigned CW = (C_CLK_DIV > 1) ? $clog2(C_CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(C_CLK_DIV - 1);

  logic [CW-1:0] cnt_clk;
  logic          tick;
  logic          h_end;
  logic          v_end;
  logic [1:0]    h_phase_nxt;
  logic [1:0]    v_phase_nxt;

  assign tick = (cnt_clk == DIV_LAST);

  vga_axis_cnt #(
    .C_VISIBLE(C_H_VISIBLE), .C_FPORCH(C_H_FPORCH),
    .C_SYNC(C_H_SYNC),       .C_BPORCH(C_H_BPORCH),
    .C_NB(C_NB_PXLS)
  ) u_h_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!en), .step(en && tick),
    .cnt(col), .cnt_end(h_end), .phase_nxt(h_phase_nxt)
  );

  // Lines advance only on the tick that wraps the column counter.
  vga_axis_cnt #(
    .C_VISIBLE(C_V_VISIBLE), .C_FPORCH(C_V_FPORCH),
    .C_SYNC(C_V_SYNC),       .C_BPORCH(C_V_BPORCH),
    .C_NB(C_NB_LINES)
  ) u_v_cnt (
    .clk(clk), .rst_n(rst_n), .clr(!en), .step(en && tick && h_end),
    .cnt(row), .cnt_end(v_end), .phase_nxt(v_phase_nxt)
  );

  // Strobes and decode are registered from the counters' next values so they
  // line up with the col/row presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_clk     <= '0;
      new_pxl     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      visible     <= 1'b0;
      hsync       <= ~C_HSYNC_ACT;
      vsync       <= ~C_VSYNC_ACT;
    end else if (!en) begin
      cnt_clk     <= '0;
      new_pxl     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      visible     <= 1'b0;
      hsync       <= ~C_HSYNC_ACT;
      vsync       <= ~C_VSYNC_ACT;
    end else begin
      cnt_clk     <= tick ? '0 : cnt_clk + 1'b1;
      new_pxl     <= tick;
      line_start  <= tick && h_end;
      frame_start <= tick && h_end && v_end;
      visible     <= (h_phase_nxt == VISIBLE) && (v_phase_nxt == VISIBLE);
      hsync       <= (h_phase_nxt == SYNC) ? C_HSYNC_ACT : ~C_HSYNC_ACT;
      vsync       <= (v_phase_nxt == SYNC) ? C_VSYNC_ACT : ~C_VSYNC_ACT;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Counts on the same edge that raises frame_start, so frame 1 reads 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   frame_cnt <= '0;
    else if (!en)                 frame_cnt <= '0;
    else if (tick && h_end && v_end) frame_cnt <= frame_cnt + 1'b1;
  end
`else
  assign frame_cnt = '0;
`endif

endmodule
